// File: rtl/sargantana_icache_mem_array.sv
// L1 instruction-cache storage: per-way tag/valid/line arrays with a walking invalidate FSM,
// per-way hit compare and a one-cycle registered read response.
module sargantana_icache_mem_array #(
   parameter int unsigned N_WAY  = 4,
   parameter int unsigned SETS   = 64,
   parameter int unsigned SET_W  = $clog2(SETS),
   parameter int unsigned LINE_W = 256,
   parameter int unsigned TAG_W  = 20
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [N_WAY-1:0]          req_i,
   input  logic                      we_i,
   input  logic [SET_W-1:0]          set_i,
   input  logic [TAG_W-1:0]          tag_i,
   input  logic [LINE_W-1:0]         line_i,
   input  logic                      vbit_i,
   input  logic [TAG_W-1:0]          cmp_tag_i,
   input  logic                      flush_i,
   output logic                      ready_o,
   output logic                      flush_busy_o,
   output logic                      flush_done_o,
   output logic                      rvalid_o,
   output logic [N_WAY*TAG_W-1:0]    tag_way_o,
   output logic [N_WAY*LINE_W-1:0]   line_way_o,
   output logic [N_WAY-1:0]          vbit_way_o,
   output logic [N_WAY-1:0]          hit_way_o
);

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      DONE  = 2'd1,
      IDLE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SET_W-1:0]   cnt_q, cnt_d;

   logic               access;
   logic               wr_en;
   logic               rd_en;
   logic               walking;

   logic [N_WAY*TAG_W-1:0]  rd_tag_c;
   logic [N_WAY*LINE_W-1:0] rd_line_c;
   logic [N_WAY-1:0]        rd_vbit_c;
   logic [N_WAY-1:0]        rd_hit_c;

   // State register and walk counter
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= FLUSH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the walk visits every set once, then a single DONE cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         FLUSH: begin
            cnt_d = cnt_q + SET_W'(1);
            if (cnt_q == SET_W'(SETS - 1)) state_d = DONE;
         end
         DONE:  state_d = IDLE;
         IDLE: begin
            if (flush_i) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = FLUSH;
            cnt_d   = '0;
         end
      endcase
   end

   // Handshake outputs decoded from state; a flush request masks ready in the same cycle
   always_comb begin
      ready_o      = 1'b0;
      flush_busy_o = 1'b0;
      flush_done_o = 1'b0;
      unique case (state_q)
         FLUSH:   flush_busy_o = 1'b1;
         DONE:    flush_done_o = 1'b1;
         IDLE:    ready_o      = ~flush_i;
         default: flush_busy_o = 1'b1;
      endcase
   end

   assign walking = (state_q == FLUSH);
   assign access  = rstn_i & ready_o & (|req_i);
   assign wr_en   = access & we_i;
   assign rd_en   = access & ~we_i;

   for (genvar w = 0; w < N_WAY; w++) begin : g_way
      logic [TAG_W-1:0]  tag_mem  [SETS];
      logic [LINE_W-1:0] line_mem [SETS];
      logic [SETS-1:0]   valid_q;

      // Tag and line storage carry no reset
      always_ff @(posedge clk_i) begin
         if (wr_en && req_i[w]) begin
            tag_mem[set_i]  <= tag_i;
            line_mem[set_i] <= line_i;
         end
      end

      // Valid bits are cleared one set per cycle by the walk
      always_ff @(posedge clk_i) begin
         if (walking) begin
            valid_q[cnt_q] <= 1'b0;
         end else if (wr_en && req_i[w]) begin
            valid_q[set_i] <= vbit_i;
         end
      end

      assign rd_tag_c[w*TAG_W +: TAG_W]    = req_i[w] ? tag_mem[set_i]  : '0;
      assign rd_line_c[w*LINE_W +: LINE_W] = req_i[w] ? line_mem[set_i] : '0;
      assign rd_vbit_c[w] = req_i[w] & valid_q[set_i];
      assign rd_hit_c[w]  = rd_vbit_c[w] & (tag_mem[set_i] == cmp_tag_i);
   end

   // Read response register: loads only on an accepted read, holds otherwise
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rvalid_o   <= 1'b0;
         tag_way_o  <= '0;
         line_way_o <= '0;
         vbit_way_o <= '0;
         hit_way_o  <= '0;
      end else begin
         rvalid_o <= rd_en;
         if (rd_en) begin
            tag_way_o  <= rd_tag_c;
            line_way_o <= rd_line_c;
            vbit_way_o <= rd_vbit_c;
            hit_way_o  <= rd_hit_c;
         end
      end
   end

endmodule

// File: tb/tb_sargantana_icache_mem_array.sv
// Scoreboard bench for sargantana_icache_mem_array: directed writes/reads/flushes with
// expected read responses queued at issue and checked by an independent monitor.
module tb_sargantana_icache_mem_array;

   localparam int unsigned N_WAY  = 4;
   localparam int          SETS   = 64;
   localparam int unsigned SET_W  = 6;
   localparam int unsigned LINE_W = 256;
   localparam int unsigned TAG_W  = 20;

   localparam logic [LINE_W-1:0] L0 = {8{32'h0101_0101}};
   localparam logic [LINE_W-1:0] L1 = {8{32'hDEAD_BEEF}};
   localparam logic [LINE_W-1:0] L2 = {8{32'h6363_6363}};
   localparam logic [LINE_W-1:0] L3 = {8{32'h7777_0000}};
   localparam logic [LINE_W-1:0] LZ = {LINE_W{1'b0}};
   localparam logic [TAG_W-1:0]  TZ = {TAG_W{1'b0}};

   typedef struct packed {
      logic [N_WAY*TAG_W-1:0]  tag;
      logic [N_WAY*LINE_W-1:0] line;
      logic [N_WAY-1:0]        vbit;
      logic [N_WAY-1:0]        hit;
   } rsp_t;

   logic                     clk;
   logic                     rstn_i;
   logic [N_WAY-1:0]         req_i;
   logic                     we_i;
   logic [SET_W-1:0]         set_i;
   logic [TAG_W-1:0]         tag_i;
   logic [LINE_W-1:0]        line_i;
   logic                     vbit_i;
   logic [TAG_W-1:0]         cmp_tag_i;
   logic                     flush_i;
   logic                     ready_o;
   logic                     flush_busy_o;
   logic                     flush_done_o;
   logic                     rvalid_o;
   logic [N_WAY*TAG_W-1:0]   tag_way_o;
   logic [N_WAY*LINE_W-1:0]  line_way_o;
   logic [N_WAY-1:0]         vbit_way_o;
   logic [N_WAY-1:0]         hit_way_o;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   sargantana_icache_mem_array #(
      .N_WAY (N_WAY),
      .SETS  (SETS),
      .SET_W (SET_W),
      .LINE_W(LINE_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn_i),
      .req_i        (req_i),
      .we_i         (we_i),
      .set_i        (set_i),
      .tag_i        (tag_i),
      .line_i       (line_i),
      .vbit_i       (vbit_i),
      .cmp_tag_i    (cmp_tag_i),
      .flush_i      (flush_i),
      .ready_o      (ready_o),
      .flush_busy_o (flush_busy_o),
      .flush_done_o (flush_done_o),
      .rvalid_o     (rvalid_o),
      .tag_way_o    (tag_way_o),
      .line_way_o   (line_way_o),
      .vbit_way_o   (vbit_way_o),
      .hit_way_o    (hit_way_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic rsp_t mk(input logic [N_WAY*TAG_W-1:0] t, input logic [N_WAY*LINE_W-1:0] l,
                               input logic [N_WAY-1:0] v, input logic [N_WAY-1:0] h);
      rsp_t r;
      r.tag  = t;
      r.line = l;
      r.vbit = v;
      r.hit  = h;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic wr(input logic [N_WAY-1:0] m, input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                     input logic [LINE_W-1:0] l, input logic v);
      req_i = m; we_i = 1'b1; set_i = s; tag_i = t; line_i = l; vbit_i = v;
      chk("wr_ready", 64'(ready_o), 64'd1);
      tick();
      req_i = '0; we_i = 1'b0;
   endtask

   task automatic rd(input logic [N_WAY-1:0] m, input logic [SET_W-1:0] s, input logic [TAG_W-1:0] c,
                     input rsp_t e);
      req_i = m; we_i = 1'b0; set_i = s; cmp_tag_i = c;
      chk("rd_ready", 64'(ready_o), 64'd1);
      exp_q.push_back(e);
      tick();
      req_i = '0;
   endtask

   // Called in the first FLUSH cycle; expects SETS busy cycles, one DONE cycle, then ready
   task automatic walk_check(input string name);
      for (int c = 1; c <= SETS + 1; c++) begin
         chk(name, 64'({ready_o, flush_busy_o, flush_done_o}),
             64'({1'b0, (c <= SETS), (c == SETS + 1)}));
         tick();
      end
      chk({name, "_ready_after"}, 64'(ready_o), 64'd1);
   endtask

   // Monitor: every rvalid must match the oldest queued expectation
   always @(negedge clk) begin
      if (rvalid_o) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rvalid_unexpected: got rvalid=1 required no response");
         end else begin
            mon_e = exp_q.pop_front();
            if ({tag_way_o, line_way_o, vbit_way_o, hit_way_o} !== mon_e) begin
               fails++;
               $display("FAIL read_rsp: got tag=%h vbit=%b hit=%b line_ok=%0b required tag=%h vbit=%b hit=%b",
                        tag_way_o, vbit_way_o, hit_way_o, (line_way_o === mon_e.line),
                        mon_e.tag, mon_e.vbit, mon_e.hit);
            end
         end
      end
   end

   initial begin
      rstn_i = 1'b0; req_i = '0; we_i = 1'b0; set_i = '0; tag_i = '0; line_i = '0;
      vbit_i = 1'b0; cmp_tag_i = '0; flush_i = 1'b0;
      repeat (3) tick();

      chk("rst_ready",  64'(ready_o),      64'd0);
      chk("rst_busy",   64'(flush_busy_o), 64'd1);
      chk("rst_done",   64'(flush_done_o), 64'd0);
      chk("rst_rvalid", 64'(rvalid_o),     64'd0);
      chk("rst_outs",   64'({|tag_way_o, |line_way_o, |vbit_way_o, |hit_way_o}), 64'd0);

      rstn_i = 1'b1;
      walk_check("post_reset_walk");

      // Multi-way write, then back-to-back reads of set 5
      wr(4'b1011, 6'd5, 20'h12345, L0, 1'b1);
      wr(4'b0100, 6'd5, 20'hABCDE, L1, 1'b1);
      rd(4'b1111, 6'd5, 20'hABCDE,
         mk({20'h12345, 20'hABCDE, 20'h12345, 20'h12345}, {L0, L1, L0, L0}, 4'b1111, 4'b0100));
      rd(4'b0011, 6'd5, 20'h12345,
         mk({TZ, TZ, 20'h12345, 20'h12345}, {LZ, LZ, L0, L0}, 4'b0011, 4'b0011));

      // Flush clears valid of set 63
      wr(4'b0001, 6'd63, 20'h00063, L2, 1'b1);
      rd(4'b0001, 6'd63, 20'h00063, mk({TZ, TZ, TZ, 20'h00063}, {LZ, LZ, LZ, L2}, 4'b0001, 4'b0001));
      flush_i = 1'b1;
      #1;
      chk("flush_ready_low", 64'(ready_o), 64'd0);
      tick();
      flush_i = 1'b0;
      walk_check("flush_walk");
      rd(4'b0001, 6'd63, 20'h00063, mk({TZ, TZ, TZ, 20'h00063}, {LZ, LZ, LZ, L2}, 4'b0000, 4'b0000));

      // Flush and read in the same cycle: flush wins, no response
      req_i = 4'b1111; we_i = 1'b0; set_i = 6'd5; cmp_tag_i = 20'hABCDE; flush_i = 1'b1;
      #1;
      chk("collide_ready_low", 64'(ready_o), 64'd0);
      tick();
      req_i = '0; flush_i = 1'b0;
      walk_check("collide_walk");
      rd(4'b1111, 6'd5, 20'hABCDE,
         mk({20'h12345, 20'hABCDE, 20'h12345, 20'h12345}, {L0, L1, L0, L0}, 4'b0000, 4'b0000));

      // Single-line invalidate keeps the tag, drops valid and hit
      wr(4'b0010, 6'd7, 20'h77777, L3, 1'b1);
      rd(4'b0010, 6'd7, 20'h77777, mk({TZ, TZ, 20'h77777, TZ}, {LZ, LZ, L3, LZ}, 4'b0010, 4'b0010));
      wr(4'b0010, 6'd7, 20'h77777, L3, 1'b0);
      chk("wr_no_rvalid", 64'(rvalid_o),  64'd0);
      chk("wr_hold_hit",  64'(hit_way_o), 64'h2);
      rd(4'b0010, 6'd7, 20'h77777, mk({TZ, TZ, 20'h77777, TZ}, {LZ, LZ, L3, LZ}, 4'b0000, 4'b0000));

      // Reset at walk count 20 restarts the walk from set 0
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      repeat (20) tick();
      chk("mid_walk_busy", 64'(flush_busy_o), 64'd1);
      rstn_i = 1'b0;
      tick();
      chk("mid_walk_rst_state", 64'({ready_o, flush_busy_o, flush_done_o}), 64'b010);
      rstn_i = 1'b1;
      walk_check("reset_walk");

      // Reset coinciding with a read drops the response and clears outputs
      req_i = 4'b0010; we_i = 1'b0; set_i = 6'd7; cmp_tag_i = 20'h77777; rstn_i = 1'b0;
      tick();
      req_i = '0;
      chk("rst_read_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_read_outs",   64'({|tag_way_o, |line_way_o}), 64'd0);
      rstn_i = 1'b1;
      walk_check("reset2_walk");

      repeat (3) tick();
      chk("pending_rsp", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
